// File: rtl/ones_pkg.sv
// ones_pkg: shared types, defaults and constant helpers for ones_pattern_gen.
package ones_pkg;
    localparam int WIDTH_DEF = 8;
    typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;
    function automatic int cw_of(input int w);
        return $clog2(w + 1);
    endfunction
    // Exact at every step: the running product is always a binomial coefficient.
    function automatic int binom(input int n, input int k);
        int r;
        r = 1;
        for (int i = 1; i <= k; i++) r = r * (n - k + i) / i;
        return r;
    endfunction
endpackage

// File: rtl/ones_next_perm.sv
// ones_next_perm: combinational Gosper successor (next larger word with the same popcount).
//   x    : current word (nonzero)
//   next : next word in increasing order with popcount(x) set bits
module ones_next_perm #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] next
);
    localparam int TZW = $clog2(WIDTH);
    logic [TZW-1:0]   tz;
    logic [WIDTH-1:0] c, r;
    always_comb begin
        tz = '0;
        for (int i = WIDTH - 1; i >= 0; i--) if (x[i]) tz = TZW'(i);
        c    = x & (~x + 1'b1);
        r    = x + c;
        // Shifting by tz replaces the divide by the lowest set bit.
        next = r | (((r ^ x) >> 2) >> tz);
    end
endmodule

// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen: streams every WIDTH-bit word with exactly n ones, in increasing order.
//   clk, rst       : clock, asynchronous active-high reset
//   start, n       : request enumeration of ones-count n (sampled in IDLE)
//   busy           : high while words are being emitted
//   valid, ready   : stream handshake for pattern
//   pattern, last  : current word, final-word marker
//   done           : one-cycle pulse after the final transfer
//   err            : n > WIDTH pulse; with ONES_GEN_CHECK_EN also sticky self-check failure
// Optional macro ONES_GEN_CHECK_EN adds the popcount and transfer-count self-check.
module ones_pattern_gen
    import ones_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = cw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CW-1:0]    n,
    output logic             busy,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] pattern,
    output logic             last,
    output logic             done,
    output logic             err
);
    localparam logic [CW-1:0] W_C = CW'(WIDTH);

    function automatic logic [WIDTH-1:0] ones(input logic [CW-1:0] k);
        logic [WIDTH:0] t;
        t = ({{WIDTH{1'b0}}, 1'b1} << k) - 1'b1;
        return t[WIDTH-1:0];
    endfunction

    state_t           state, state_d;
    logic [CW-1:0]    n_q, n_d;
    logic [WIDTH-1:0] pattern_q, pattern_d, next_w;
    logic             err_q, err_d;

    ones_next_perm #(.WIDTH(WIDTH)) u_next (.x(pattern_q), .next(next_w));

    assign busy    = (state == EMIT);
    assign valid   = busy;
    assign done    = (state == FIN);
    assign pattern = pattern_q;
    assign last    = valid && (pattern_q == (ones(n_q) << (W_C - n_q)));

    always_comb begin
        state_d   = state;
        n_d       = n_q;
        pattern_d = pattern_q;
        err_d     = 1'b0;
        case (state)
            IDLE: if (start) begin
                if (n > W_C) err_d = 1'b1;
                else begin
                    n_d       = n;
                    pattern_d = ones(n);
                    state_d   = EMIT;
                end
            end
            EMIT: if (ready) begin
                if (last) state_d = FIN;
                else pattern_d = next_w;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            n_q       <= '0;
            pattern_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_d;
            n_q       <= n_d;
            pattern_q <= pattern_d;
            err_q     <= err_d;
        end
    end

`ifdef ONES_GEN_CHECK_EN
    logic [15:0]   cnt, exp_cnt;
    logic [CW-1:0] pc_q;
    logic          chk_v, sticky, accept;

    assign accept = (state == IDLE) && start && (n <= W_C);

    always_comb begin
        exp_cnt = '0;
        for (int i = 0; i <= WIDTH; i++) if (n_q == CW'(i)) exp_cnt = 16'(binom(WIDTH, i));
    end

    // Popcount is registered, so each word is checked one cycle after it is shown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            pc_q   <= '0;
            chk_v  <= 1'b0;
            sticky <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            chk_v  <= 1'b0;
            sticky <= 1'b0;
        end else begin
            chk_v <= valid;
            pc_q  <= CW'($countones(pattern_q));
            if (valid && ready) cnt <= cnt + 1'b1;
            if ((chk_v && pc_q != n_q) || (state == FIN && cnt != exp_cnt)) sticky <= 1'b1;
        end
    end

    assign err = err_q | sticky;
`else
    assign err = err_q;
`endif
endmodule
